// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline backbone: control-word bit
// positions, forwarding select encodings and the canonical NOP.
package pipe_pkg;

    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMTOREG  = 1;
    localparam int CTRL_MEMREAD   = 2;
    localparam int CTRL_MEMWRITE  = 3;
    localparam int CTRL_BRANCH_LO = 4;
    localparam int CTRL_BRANCH_HI = 5;
    localparam int CTRL_ALUSRC    = 6;
    localparam int CTRL_ALUOP_LO  = 7;
    localparam int CTRL_ALUOP_HI  = 8;
    localparam int CTRL_JUMP      = 9;

    localparam logic [1:0] FWD_IDEX  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Forwarding compare for one ALU operand: picks EX/MEM, then MEM/WB, else ID/EX.
module pipe_fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] src_reg,
    input  logic                  exmem_regwrite,
    input  logic [REG_ADDR_W-1:0] exmem_wreg,
    input  logic                  memwb_regwrite,
    input  logic [REG_ADDR_W-1:0] memwb_wreg,
    output logic [1:0]            sel
);

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

    // Younger producer (EX/MEM) wins; register $0 never forwards.
    always_comb begin
        sel = FWD_IDEX;
        if (exmem_regwrite && (exmem_wreg != REG_ZERO) && (exmem_wreg == src_reg)) begin
            sel = FWD_EXMEM;
        end else if (memwb_regwrite && (memwb_wreg != REG_ZERO) && (memwb_wreg == src_reg)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_IDEX;
        end
    end

endmodule

// File: rtl/pipe_hazard_regs.sv
// Pipeline registers, load-use stall, redirect flush and forwarding selects.
// Optional macro PIPE_WB_BYPASS_EN: ID/EX latches the writeback value on a MEM/WB hit.
module pipe_hazard_regs
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     if_pc4,
    input  logic [31:0]           if_instr,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [REG_ADDR_W-1:0] id_wreg,
    input  logic [DATA_W-1:0]     ex_alu,
    input  logic [DATA_W-1:0]     ex_store,
    input  logic                  ex_redirect,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  pc_stall,
    output logic [DATA_W-1:0]     ifid_pc4,
    output logic [31:0]           ifid_instr,
    output logic [CTRL_W-1:0]     idex_ctrl,
    output logic [DATA_W-1:0]     idex_rd1,
    output logic [DATA_W-1:0]     idex_rd2,
    output logic [DATA_W-1:0]     idex_imm,
    output logic [REG_ADDR_W-1:0] idex_rs,
    output logic [REG_ADDR_W-1:0] idex_rt,
    output logic [REG_ADDR_W-1:0] idex_wreg,
    output logic [CTRL_W-1:0]     exmem_ctrl,
    output logic [DATA_W-1:0]     exmem_alu,
    output logic [DATA_W-1:0]     exmem_wdata,
    output logic [REG_ADDR_W-1:0] exmem_wreg,
    output logic [CTRL_W-1:0]     memwb_ctrl,
    output logic [DATA_W-1:0]     memwb_alu,
    output logic [DATA_W-1:0]     memwb_rdata,
    output logic [REG_ADDR_W-1:0] memwb_wreg,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    localparam logic [DATA_W-1:0]     DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [CTRL_W-1:0]     CTRL_ZERO = {CTRL_W{1'b0}};
    localparam logic [REG_ADDR_W-1:0] REG_ZERO  = {REG_ADDR_W{1'b0}};

    logic [REG_ADDR_W-1:0] ifid_rs_s;
    logic [REG_ADDR_W-1:0] ifid_rt_s;
    logic                  load_use_s;
    logic [DATA_W-1:0]     id_rd1_sel_s;
    logic [DATA_W-1:0]     id_rd2_sel_s;

    assign ifid_rs_s = ifid_instr[21 +: REG_ADDR_W];
    assign ifid_rt_s = ifid_instr[16 +: REG_ADDR_W];

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_use_s = 1'b0;
        if (idex_ctrl[CTRL_MEMREAD] && (idex_wreg != REG_ZERO) &&
            ((idex_wreg == ifid_rs_s) || (idex_wreg == ifid_rt_s))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
    end

    // A redirect discards the stalled instruction anyway, so it overrides the stall.
    assign pc_stall = load_use_s & ~ex_redirect;

`ifdef PIPE_WB_BYPASS_EN
    logic [DATA_W-1:0] wb_val_s;
    logic              wb_live_s;

    // Substitute the value being written back this cycle for a stale register-file read.
    always_comb begin
        wb_val_s     = memwb_ctrl[CTRL_MEMTOREG] ? memwb_rdata : memwb_alu;
        wb_live_s    = memwb_ctrl[CTRL_REGWRITE] && (memwb_wreg != REG_ZERO);
        id_rd1_sel_s = id_rd1;
        id_rd2_sel_s = id_rd2;
        if (wb_live_s && (memwb_wreg == ifid_rs_s)) begin
            id_rd1_sel_s = wb_val_s;
        end else begin
            id_rd1_sel_s = id_rd1;
        end
        if (wb_live_s && (memwb_wreg == ifid_rt_s)) begin
            id_rd2_sel_s = wb_val_s;
        end else begin
            id_rd2_sel_s = id_rd2;
        end
    end
`else
    assign id_rd1_sel_s = id_rd1;
    assign id_rd2_sel_s = id_rd2;
`endif

    // IF/ID: flush on redirect, hold on load-use stall, else capture fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_pc4   <= DATA_ZERO;
            ifid_instr <= NOP_INSTR;
        end else if (ex_redirect) begin
            ifid_pc4   <= DATA_ZERO;
            ifid_instr <= NOP_INSTR;
        end else if (load_use_s) begin
            ifid_pc4   <= ifid_pc4;
            ifid_instr <= ifid_instr;
        end else begin
            ifid_pc4   <= if_pc4;
            ifid_instr <= if_instr;
        end
    end

    // ID/EX: bubble on redirect or stall, else capture decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_ctrl <= CTRL_ZERO;
            idex_rd1  <= DATA_ZERO;
            idex_rd2  <= DATA_ZERO;
            idex_imm  <= DATA_ZERO;
            idex_rs   <= REG_ZERO;
            idex_rt   <= REG_ZERO;
            idex_wreg <= REG_ZERO;
        end else if (ex_redirect || load_use_s) begin
            idex_ctrl <= CTRL_ZERO;
            idex_rd1  <= DATA_ZERO;
            idex_rd2  <= DATA_ZERO;
            idex_imm  <= DATA_ZERO;
            idex_rs   <= REG_ZERO;
            idex_rt   <= REG_ZERO;
            idex_wreg <= REG_ZERO;
        end else begin
            idex_ctrl <= id_ctrl;
            idex_rd1  <= id_rd1_sel_s;
            idex_rd2  <= id_rd2_sel_s;
            idex_imm  <= id_imm;
            idex_rs   <= ifid_rs_s;
            idex_rt   <= ifid_rt_s;
            idex_wreg <= id_wreg;
        end
    end

    // EX/MEM: always advances, including the redirecting instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exmem_ctrl  <= CTRL_ZERO;
            exmem_alu   <= DATA_ZERO;
            exmem_wdata <= DATA_ZERO;
            exmem_wreg  <= REG_ZERO;
        end else begin
            exmem_ctrl  <= idex_ctrl;
            exmem_alu   <= ex_alu;
            exmem_wdata <= ex_store;
            exmem_wreg  <= idex_wreg;
        end
    end

    // MEM/WB: always advances; MemtoReg selection happens downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            memwb_ctrl  <= CTRL_ZERO;
            memwb_alu   <= DATA_ZERO;
            memwb_rdata <= DATA_ZERO;
            memwb_wreg  <= REG_ZERO;
        end else begin
            memwb_ctrl  <= exmem_ctrl;
            memwb_alu   <= exmem_alu;
            memwb_rdata <= mem_rdata;
            memwb_wreg  <= exmem_wreg;
        end
    end

    pipe_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src_reg        (idex_rs),
        .exmem_regwrite (exmem_ctrl[CTRL_REGWRITE]),
        .exmem_wreg     (exmem_wreg),
        .memwb_regwrite (memwb_ctrl[CTRL_REGWRITE]),
        .memwb_wreg     (memwb_wreg),
        .sel            (fwd_a)
    );

    pipe_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src_reg        (idex_rt),
        .exmem_regwrite (exmem_ctrl[CTRL_REGWRITE]),
        .exmem_wreg     (exmem_wreg),
        .memwb_regwrite (memwb_ctrl[CTRL_REGWRITE]),
        .memwb_wreg     (memwb_wreg),
        .sel            (fwd_b)
    );

endmodule

// File: doc/pipe_hazard_regs.md
Name: pipe_hazard_regs

Overview:
Parametrised 5-stage pipeline backbone that replaces the single-cycle datapath's direct stage-to-stage wiring. It holds the IF/ID, ID/EX, EX/MEM and MEM/WB registers, detects load-use hazards (stall plus bubble), flushes on taken branch or jump, and produces the forwarding selects for the ALU operand muxes. Combinational stage logic (Control, Register_File, ALU, Data_Memory, PC adder) stays outside and connects through this block.

Parameters:
DATA_W, 32, datapath/PC width
REG_ADDR_W, 5, register index width
CTRL_W, 10, decoded control word width; bit positions are fixed in the package

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high
if_pc4  in  DATA_W  PC+4 from fetch
if_instr  in  32  fetched instruction
id_ctrl  in  CTRL_W  decoded control from Control
id_rd1, id_rd2  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_wreg  in  REG_ADDR_W  destination register after the RegDst mux
ex_alu  in  DATA_W  ALU result
ex_store  in  DATA_W  forwarded rt value, used as store data
ex_redirect  in  1  branch taken or jump resolved in EX
mem_rdata  in  DATA_W  data-memory read data
pc_stall  out  1  hold PC (combinational)
ifid_pc4, ifid_instr  out  DATA_W/32  IF/ID register
idex_ctrl, idex_rd1, idex_rd2, idex_imm  out  CTRL_W/DATA_W  ID/EX register
idex_rs, idex_rt, idex_wreg  out  REG_ADDR_W  ID/EX register
exmem_ctrl, exmem_alu, exmem_wdata, exmem_wreg  out  EX/MEM register
memwb_ctrl, memwb_alu, memwb_rdata, memwb_wreg  out  MEM/WB register
fwd_a, fwd_b  out  2  ALU operand source: 00 = ID/EX, 10 = EX/MEM, 01 = MEM/WB (combinational)

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-high. Every register clears to 0: instruction 0 (NOP), ctrl 0, data 0. pc_stall=0, fwd_a=fwd_b=00.
- Normal flow: each register captures the previous stage's inputs on every rising edge. Each stage adds one cycle of latency.
- Load-use stall:
  - Condition: idex_ctrl[MEMREAD]=1, idex_wreg≠0, and idex_wreg equals ifid_instr[25:21] or ifid_instr[20:16].
  - Response: pc_stall=1; IF/ID holds; ID/EX loads a bubble (ctrl=0, other fields don't-care, driven 0); EX/MEM and MEM/WB advance normally.
  - The stall lasts exactly 1 cycle.
- Redirect: ex_redirect=1 at an edge flushes IF/ID (instr=0, pc4=0) and ID/EX (ctrl=0).
  - Redirect has priority over stall: pc_stall is forced 0 when ex_redirect=1.
  - The EX instruction itself still advances into EX/MEM.
- Forwarding (fwd_a uses idex_rs, fwd_b uses idex_rt):
  - Select 10 if exmem_ctrl[REGWRITE], exmem_wreg≠0 and exmem_wreg matches.
  - Otherwise select 01 if memwb_ctrl[REGWRITE], memwb_wreg≠0 and memwb_wreg matches.
  - Otherwise select 00. EX/MEM wins when both match.
- Register $0 is never a hazard or forwarding source.
- exmem_wdata captures ex_store. memwb_alu and memwb_rdata both pass through; MemtoReg selection stays outside.
- Reset asserted mid-stall or mid-flush clears all stages immediately; there is no residual stall after release.

Optional Feature:
PIPE_WB_BYPASS_EN
- Defined: when ID/EX captures, if memwb_ctrl[REGWRITE], memwb_wreg≠0 and memwb_wreg equals ifid rs (rt), idex_rd1 (idex_rd2) latches the writeback value (memwb_rdata if memwb_ctrl[MEMTOREG] else memwb_alu) instead of id_rd1 (id_rd2). This covers a register file without a write-first read.
- Undefined: id_rd1/id_rd2 are latched unmodified, and the register file must write on the falling edge.

Decomposition:
- Package pipe_pkg: control-bit indices CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_MEMREAD=2, CTRL_MEMWRITE=3, CTRL_BRANCH=4..5, CTRL_ALUSRC=6, CTRL_ALUOP=7..8, CTRL_JUMP=9; FWD_IDEX/FWD_EXMEM/FWD_MEMWB encodings; NOP_INSTR=0.
- One sub-module, pipe_fwd_unit: combinational forwarding compare, instantiated once per operand.

Test Plan:
- Reset mid-run with all stages valid: all outputs read 0 in the same cycle as reset assertion (asynchronous); the first instruction reappears in ifid_instr one cycle after release.
- add $3,$1,$2 then sub $4,$3,$5: while sub is in EX, fwd_a=10; with a nop inserted between them, fwd_a=01.
- lw $2,0($1) then add $4,$2,$2: pc_stall=1 for exactly 1 cycle, idex_ctrl=0 bubble, then fwd_a=fwd_b=01 for add.
- Branch in EX with ex_redirect=1 while a load-use condition is also present: pc_stall=0, ifid_instr=0, idex_ctrl=0, and the branch's ctrl reaches exmem_ctrl.
- Writes to $0 (exmem_wreg=0 with REGWRITE=1) followed by a use of $0: fwd=00 and no stall.
- PIPE_WB_BYPASS_EN defined: memwb writes $7=0x1234 while ID reads $7 with id_rd1=0 → idex_rd1=0x1234; undefined → idex_rd1=0.
